rp_8bit_fetch: RTL



---
 rtl/rp_8bit_fetch_if.sv | 27 ++
 rtl/rp_8bit_fetch.sv | 103 ++++++++++
 2 files changed

// File: rtl/rp_8bit_fetch_if.sv
// Fetch-stage bus bundle: program memory port, decoder issue port, skip/redirect controls.
// The fetch side owns pmem request and instruction outputs; the core side owns the rest.
interface rp_8bit_fetch_if #(
   parameter int PAW = 11
);
   logic           pmem_ce;
   logic [PAW-1:0] pmem_adr;
   logic [15:0]    pmem_rdt;
   logic           ins_vld;
   logic           ins_rdy;
   logic [31:0]    ins_code;
   logic           ins_len;
   logic [PAW-1:0] ins_pc;
   logic           skp_vld;
   logic           jmp_vld;
   logic [PAW-1:0] jmp_adr;

   modport master (
      output pmem_ce, pmem_adr, ins_vld, ins_code, ins_len, ins_pc,
      input  pmem_rdt, ins_rdy, skp_vld, jmp_vld, jmp_adr
   );

   modport slave (
      input  pmem_ce, pmem_adr, ins_vld, ins_code, ins_len, ins_pc,
      output pmem_rdt, ins_rdy, skp_vld, jmp_vld, jmp_adr
   );
endinterface

// File: rtl/rp_8bit_fetch.sv
// Prefetch buffer + 16/32-bit instruction assembly with skip and redirect; issue >= 2 cycles after pmem_ce.
// Backpressure: ins_vld holds stable while ins_rdy=0; fetch stops once buffered+in-flight words reach DEPTH.
module rp_8bit_fetch #(
   parameter int PAW     = 11,
   parameter int DEPTH   = 4,
   parameter int RST_ADR = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   rp_8bit_fetch_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {BOOT, RUN, SKIP} state_t;

   state_t         state;
   logic [15:0]    fb_dat [DEPTH];
   logic [PAW-1:0] fb_adr [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [CW-1:0]  cnt;
   logic           fl_vld;
   logic           fl_epoch;
   logic [PAW-1:0] fl_adr;
   logic           epoch;
   logic [PAW-1:0] fetch_adr;

   logic [15:0]    head;
   logic [15:0]    second;
   logic           len;
   logic           full_ins;
   logic           hs;
   logic           skp_pop;
   logic           wr_en;
   logic           ce;
   logic [1:0]     pop_n;

   assign head     = fb_dat[rd_ptr];
   assign second   = fb_dat[rd_ptr + AW'(1)];
   assign len      = ((head & 16'hFC0F) == 16'h9000) || ((head & 16'hFE0C) == 16'h940C);
   assign full_ins = cnt >= (len ? CW'(2) : CW'(1));
   assign hs       = bus.ins_vld && bus.ins_rdy;
   assign skp_pop  = (state == SKIP) && full_ins;
   assign pop_n    = (hs || skp_pop) ? (len ? 2'd2 : 2'd1) : 2'd0;
   // Reads issued before the latest redirect carry a stale epoch and are discarded on return.
   assign wr_en    = fl_vld && (fl_epoch == epoch) && !bus.jmp_vld;
   assign ce       = (state != BOOT) && ((cnt + CW'(fl_vld)) < CW'(DEPTH));

   assign bus.pmem_ce  = ce;
   assign bus.pmem_adr = fetch_adr;
   assign bus.ins_vld  = (state == RUN) && full_ins;
   assign bus.ins_code = {(len ? second : 16'h0000), head};
   assign bus.ins_len  = len;
   assign bus.ins_pc   = fb_adr[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BOOT;
         fetch_adr <= PAW'(RST_ADR);
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         cnt       <= '0;
         fl_vld    <= 1'b0;
         fl_epoch  <= 1'b0;
         fl_adr    <= '0;
         epoch     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            fb_dat[i] <= '0;
            fb_adr[i] <= '0;
         end
      end else begin
         fl_vld   <= ce;
         fl_epoch <= epoch;
         fl_adr   <= fetch_adr;
         if (wr_en) begin
            fb_dat[wr_ptr] <= bus.pmem_rdt;
            fb_adr[wr_ptr] <= fl_adr;
         end
         if (bus.jmp_vld) begin
            epoch     <= ~epoch;
            fetch_adr <= bus.jmp_adr;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            state     <= RUN;
         end else begin
            if (ce)
               fetch_adr <= fetch_adr + PAW'(1);
            if (wr_en)
               wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr + AW'(pop_n);
            cnt    <= cnt + CW'(wr_en) - CW'(pop_n);
            case (state)
               BOOT:    state <= RUN;
               RUN:     if (hs && bus.skp_vld) state <= SKIP;
               SKIP:    if (skp_pop) state <= RUN;
               default: state <= BOOT;
            endcase
         end
      end
   end
endmodule
